// File: rtl/key_cmd_arbiter_if.sv
// rtl/key_cmd_arbiter_if.sv - key-state input and command output bundle for key_cmd_arbiter
interface key_cmd_arbiter_if;
  logic         play_en;
  logic [511:0] key_down;
  logic         cmd_valid;
  logic [2:0]   cmd;

  modport master (
    output play_en,
    output key_down,
    input  cmd_valid,
    input  cmd
  );

  modport slave (
    input  play_en,
    input  key_down,
    output cmd_valid,
    output cmd
  );
endinterface

// File: rtl/key_cmd_arbiter.sv
// rtl/key_cmd_arbiter.sv - key press/auto-repeat detection and priority command arbiter
// KEY_AUTOREPEAT_EN enables the horizontal and vertical hold-to-repeat channels.
module key_cmd_arbiter #(
  parameter int DAS_DELAY = 16_000_000,
  parameter int DAS_RATE  = 5_000_000,
  parameter int CNT_W     = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  key_cmd_arbiter_if.slave  bus
);
  localparam logic [8:0] CODE_LEFT   = 9'h01C;
  localparam logic [8:0] CODE_RIGHT  = 9'h023;
  localparam logic [8:0] CODE_ROTATE = 9'h01D;
  localparam logic [8:0] CODE_DOWN   = 9'h01B;
  localparam logic [8:0] CODE_DROP   = 9'h029;

  if (CNT_W < 1 || DAS_DELAY < 1 || DAS_RATE < 1) begin : g_bad_cfg
  end

  // Bit index equals the command code: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DOWN, 4 DROP.
  logic [4:0] key_cur, kd_q, press, rep_ev;
  logic [4:0] pend_q, pend_d, cand, grant;
  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_q, cmd_d;
  logic       unused_keys;

  assign key_cur = {bus.key_down[CODE_DROP], bus.key_down[CODE_DOWN],
                    bus.key_down[CODE_ROTATE], bus.key_down[CODE_RIGHT],
                    bus.key_down[CODE_LEFT]};
  assign press = key_cur & ~kd_q & {5{bus.play_en}};
  assign unused_keys = ^bus.key_down;

`ifdef KEY_AUTOREPEAT_EN
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_e;

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(DAS_RATE - 1);

  rep_state_e       h_state_q, h_state_d, v_state_q, v_state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             h_dir_q, h_dir_d, h_rep, v_rep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_state_q <= R_IDLE;
      v_state_q <= R_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      h_dir_q   <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_dir_q   <= h_dir_d;
    end
  end

  // A fresh LEFT/RIGHT press always takes over the channel; LEFT wins a same-cycle tie.
  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    h_dir_d   = h_dir_q;
    h_rep     = 1'b0;
    if (!bus.play_en) begin
      h_state_d = R_IDLE;
    end else if (press[0] || press[1]) begin
      h_dir_d   = ~press[0];
      h_cnt_d   = DELAY_LD;
      h_state_d = R_DELAY;
    end else if (h_state_q != R_IDLE) begin
      if (!(h_dir_q ? key_cur[1] : key_cur[0])) begin
        h_state_d = R_IDLE;
      end else if (h_cnt_q == '0) begin
        h_rep     = 1'b1;
        h_cnt_d   = RATE_LD;
        h_state_d = R_REPEAT;
      end else begin
        h_cnt_d = h_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    v_rep     = 1'b0;
    if (!bus.play_en) begin
      v_state_d = R_IDLE;
    end else if (press[3]) begin
      v_cnt_d   = DELAY_LD;
      v_state_d = R_DELAY;
    end else if (v_state_q != R_IDLE) begin
      if (!key_cur[3]) begin
        v_state_d = R_IDLE;
      end else if (v_cnt_q == '0) begin
        v_rep     = 1'b1;
        v_cnt_d   = RATE_LD;
        v_state_d = R_REPEAT;
      end else begin
        v_cnt_d = v_cnt_q - 1'b1;
      end
    end
  end

  assign rep_ev = {1'b0, v_rep, 1'b0, h_rep & h_dir_q, h_rep & ~h_dir_q};
`else
  assign rep_ev = '0;
`endif

  // Priority DROP > ROTATE > LEFT > RIGHT > DOWN; losers stay in pend.
  always_comb begin
    cand        = pend_q | press | rep_ev;
    grant       = '0;
    cmd_d       = cmd_q;
    cmd_valid_d = |cand;
    if (cand[4]) begin
      grant = 5'b10000; cmd_d = 3'd4;
    end else if (cand[2]) begin
      grant = 5'b00100; cmd_d = 3'd2;
    end else if (cand[0]) begin
      grant = 5'b00001; cmd_d = 3'd0;
    end else if (cand[1]) begin
      grant = 5'b00010; cmd_d = 3'd1;
    end else if (cand[3]) begin
      grant = 5'b01000; cmd_d = 3'd3;
    end
    pend_d = cand & ~grant;
    if (!bus.play_en) begin
      cmd_valid_d = 1'b0;
      cmd_d       = cmd_q;
      pend_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kd_q        <= '0;
      pend_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 3'd0;
    end else begin
      kd_q        <= key_cur;
      pend_q      <= pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
endmodule
